// File: rtl/tli4970_pkg.sv
// Shared constants, FSM state type and register map for the TLI4970 sensor emulator.
package tli4970_pkg;
  localparam int TYPE_BIT    = 15;
  localparam int CURRENT_MSB = 12;
  localparam int STATUS_W    = 15;
  localparam int FRAME_BITS  = 16;
  localparam int CNT_W       = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

  localparam logic [7:0]  ADDR_STATUS = 8'h10;
  localparam logic [7:0]  ADDR_DONE   = 8'h20;
  localparam logic [7:0]  ADDR_ABORT  = 8'h21;
  localparam logic [7:0]  ADDR_CONFL  = 8'h22;
  localparam logic [31:0] RD_UNMAPPED = 32'hdeadbeef;

  // A pending status word wins over the current reading for exactly one frame.
  function automatic logic [FRAME_BITS-1:0] frame_word(
    input logic                 pending,
    input logic [STATUS_W-1:0]  status,
    input logic [CURRENT_MSB:0] current
  );
    return pending ? {1'b1, status} : {3'b000, current};
  endfunction
endpackage

// File: rtl/tli4970_emulator_spi_slave_shifter.sv
// SPI slave datapath: input synchronizers, edge detect, 16-bit output shifter and fall counter.
module spi_slave_shifter
  import tli4970_pkg::*;
#(
  parameter int NUMBER_OF_SENSORS = 2,
  parameter int SYNC_STAGES       = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUMBER_OF_SENSORS-1:0] ss_n_i,
  input  logic                         sck_i,
  input  logic                         load,
  input  logic [FRAME_BITS-1:0]        load_word,
  input  logic                         active,
  input  logic                         stop,
  output logic [NUMBER_OF_SENSORS-1:0] ss_sync,
  output logic [NUMBER_OF_SENSORS-1:0] ss_fall,
  output logic [CNT_W-1:0]             bit_cnt,
  output logic                         miso_o,
  output logic                         miso_oe
);
  logic [SYNC_STAGES-1:0][NUMBER_OF_SENSORS-1:0] ss_pipe;
  logic [SYNC_STAGES-1:0]                        sck_pipe;
  logic [NUMBER_OF_SENSORS-1:0]                  ss_prev;
  logic                                          sck_prev, sck_sync, sck_rise, sck_fall;
  logic [FRAME_BITS-1:0]                         shreg;

  assign ss_sync  = ss_pipe[SYNC_STAGES-1];
  assign sck_sync = sck_pipe[SYNC_STAGES-1];
  assign ss_fall  = ss_prev & ~ss_sync;
  assign sck_rise = sck_sync & ~sck_prev;
  assign sck_fall = ~sck_sync & sck_prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ss_pipe  <= '1;
      sck_pipe <= '0;
      ss_prev  <= '1;
      sck_prev <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      miso_o   <= 1'b0;
      miso_oe  <= 1'b0;
    end else begin
      ss_pipe  <= {ss_pipe[SYNC_STAGES-2:0], ss_n_i};
      sck_pipe <= {sck_pipe[SYNC_STAGES-2:0], sck_i};
      ss_prev  <= ss_sync;
      sck_prev <= sck_sync;
      if (load) begin
        shreg   <= load_word;
        miso_o  <= load_word[FRAME_BITS-1];
        miso_oe <= 1'b1;
        bit_cnt <= '0;
      end else if (stop) begin
        miso_o  <= 1'b0;
        miso_oe <= 1'b0;
      end else if (active) begin
        // MSB is already on the line, so the first rise has nothing to shift;
        // zeros shifted in keep miso low on surplus edges.
        if (sck_rise && bit_cnt != '0) begin
          shreg  <= {shreg[FRAME_BITS-2:0], 1'b0};
          miso_o <= shreg[FRAME_BITS-2];
        end
        if (sck_fall && bit_cnt != CNT_W'(FRAME_BITS))
          bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/tli4970_emulator.sv
// TLI4970 multi-sensor emulator: Avalon-MM register file, chip-select arbitration and frame counters.
module tli4970_emulator
  import tli4970_pkg::*;
#(
  parameter int NUMBER_OF_SENSORS = 2,
  parameter int SYNC_STAGES       = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [7:0]                   address,
  input  logic                         write,
  input  logic [31:0]                  writedata,
  input  logic                         read,
  output logic [31:0]                  readdata,
  output logic                         waitrequest,
  input  logic [NUMBER_OF_SENSORS-1:0] ss_n_i,
  input  logic                         sck_i,
  output logic                         miso_o,
  output logic                         miso_oe
);
  localparam int IDXW = (NUMBER_OF_SENSORS > 1) ? $clog2(NUMBER_OF_SENSORS) : 1;

  logic [NUMBER_OF_SENSORS-1:0][CURRENT_MSB:0] cur_q;
  logic [NUMBER_OF_SENSORS-1:0][STATUS_W-1:0]  st_q;
  logic [NUMBER_OF_SENSORS-1:0]                pend_q;
  logic [31:0]                                 done_q, abort_q, confl_q, rd_mux;
  logic                                        rd_ack;
  state_t                                      state_q, state_d;
  logic [IDXW-1:0]                             sel_q, sel_d;
  logic                                        load, stop, inc_done, inc_abort, inc_confl, cnt_clr;
  logic [FRAME_BITS-1:0]                       word;
  logic [NUMBER_OF_SENSORS-1:0]                ss_sync, ss_fall;
  logic [CNT_W-1:0]                            bit_cnt;

  spi_slave_shifter #(
    .NUMBER_OF_SENSORS(NUMBER_OF_SENSORS),
    .SYNC_STAGES      (SYNC_STAGES)
  ) u_shifter (
    .clock    (clock),
    .reset    (reset),
    .ss_n_i   (ss_n_i),
    .sck_i    (sck_i),
    .load     (load),
    .load_word(word),
    .active   (state_q == ST_SHIFT),
    .stop     (stop),
    .ss_sync  (ss_sync),
    .ss_fall  (ss_fall),
    .bit_cnt  (bit_cnt),
    .miso_o   (miso_o),
    .miso_oe  (miso_oe)
  );

  always_comb begin
    word = '0;
    for (int i = 0; i < NUMBER_OF_SENSORS; i++)
      if (sel_q == IDXW'(i)) word = frame_word(pend_q[i], st_q[i], cur_q[i]);
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    load      = 1'b0;
    stop      = 1'b0;
    inc_done  = 1'b0;
    inc_abort = 1'b0;
    inc_confl = 1'b0;
    unique case (state_q)
      ST_IDLE:
        if (|ss_fall) begin
          state_d   = ST_LOAD;
          inc_confl = $countones(~ss_sync) > 1;
          for (int i = NUMBER_OF_SENSORS - 1; i >= 0; i--)
            if (!ss_sync[i]) sel_d = IDXW'(i);
        end
      ST_LOAD: begin
        load    = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        // Only the line that started the frame can end it.
        for (int i = 0; i < NUMBER_OF_SENSORS; i++)
          if (sel_q == IDXW'(i) && ss_sync[i]) stop = 1'b1;
        if (stop) begin
          state_d   = ST_IDLE;
          inc_done  = (bit_cnt == CNT_W'(FRAME_BITS));
          inc_abort = (bit_cnt != CNT_W'(FRAME_BITS));
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = RD_UNMAPPED;
    case (address)
      ADDR_DONE:  rd_mux = done_q;
      ADDR_ABORT: rd_mux = abort_q;
      ADDR_CONFL: rd_mux = confl_q;
      default:    ;
    endcase
    for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
      if (address == 8'(i))               rd_mux = {{(31-CURRENT_MSB){cur_q[i][CURRENT_MSB]}}, cur_q[i]};
      if (address == ADDR_STATUS + 8'(i)) rd_mux = {pend_q[i], 16'b0, st_q[i]};
    end
  end

  assign waitrequest = read & ~rd_ack;
  assign cnt_clr     = write && (address == ADDR_DONE || address == ADDR_ABORT || address == ADDR_CONFL);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      cur_q    <= '0;
      st_q     <= '0;
      pend_q   <= '0;
      done_q   <= '0;
      abort_q  <= '0;
      confl_q  <= '0;
      readdata <= '0;
      rd_ack   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rd_ack  <= read & ~rd_ack;
      if (read && !rd_ack) readdata <= rd_mux;
      for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
        if (write && address == 8'(i)) cur_q[i] <= writedata[CURRENT_MSB:0];
        // A host status write in the same cycle as the frame load keeps the new word pending.
        if (write && address == ADDR_STATUS + 8'(i)) begin
          st_q[i]   <= writedata[STATUS_W-1:0];
          pend_q[i] <= 1'b1;
        end else if (load && sel_q == IDXW'(i)) begin
          pend_q[i] <= 1'b0;
        end
      end
      if (cnt_clr) begin
        done_q  <= '0;
        abort_q <= '0;
        confl_q <= '0;
      end else begin
        if (inc_done)  done_q  <= done_q + 1'b1;
        if (inc_abort) abort_q <= abort_q + 1'b1;
        if (inc_confl) confl_q <= confl_q + 1'b1;
      end
    end
  end
endmodule
